frac_to_dec_stream: RTL and testbench
=====================================

FRAC_TO_DEC_STREAM -- requirements
Module: frac_to_dec_stream

Interface
REQ-001 SHALL have parameter W, default 400: total input width, fixed-point binary.
REQ-002 SHALL have parameter INT_BITS, default 4: integer bits at binary[W-1 -: INT_BITS]; the remaining W-INT_BITS bits are the fraction.
REQ-003 SHALL have parameter N_FRAC, default 100: fractional decimal digits emitted per conversion.
REQ-004 SHALL have parameter ASCII, default 0: 0 = raw BCD digit on digit[3:0]; 1 = ASCII code with '.' separator.
REQ-005 SHALL have one clock; reset is synchronous and active-high: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-006 SHALL have start input 1: one-cycle request, sampled only in IDLE.
REQ-007 SHALL have binary input W: value to convert, captured on the accepted start.
REQ-008 SHALL have ready input 1: consumer accepts digit when ready && valid.
REQ-009 SHALL have digit output 8: current symbol; BCD zero-extended, or ASCII.
REQ-010 SHALL have valid output 1: digit is meaningful.
REQ-011 SHALL have busy output 1: high from accepted start until done.
REQ-012 SHALL have done output 1: one-cycle pulse at end of conversion.
REQ-013 SHALL have err output 1: integer part >9; held until the next accepted start.

Function
REQ-014 SHALL implement states IDLE, INT, DOT, MUL, FRAC and FIN.
REQ-015 In IDLE with start=1, SHALL capture binary into an internal integer register (INT_BITS) and fraction register (W-INT_BITS), clear err, set busy, and go to INT.
REQ-016 Start while busy SHALL be ignored, with no effect on the captured value or sequence.
REQ-017 In INT, if integer >9: SHALL set err=1, keep valid=0, go to FIN; otherwise SHALL drive valid=1 with the integer digit.
REQ-018 On an INT handshake, SHALL go to DOT when ASCII=1 (digit=8'h2E, valid=1), else to MUL.
REQ-019 On a DOT handshake, SHALL go to MUL.
REQ-020 In MUL (valid=0, one cycle), SHALL compute product = fraction*10 via (f<<3)+(f<<1) in W-INT_BITS+4 bits; the upper 4 bits are the next digit (0..9) and the lower W-INT_BITS bits are the new fraction; then go to FRAC.
REQ-021 In FRAC, SHALL drive valid=1 with that digit; on handshake, increment the digit counter and go to FIN if N_FRAC digits have been emitted, else to MUL.
REQ-022 ASCII=1 SHALL give digit = 8'h30 + d; ASCII=0 SHALL give digit = {4'h0, d}.
REQ-023 While valid=1 and ready=0, digit and state SHALL stay stable for any number of cycles.
REQ-024 Valid SHALL never drop without a handshake.
REQ-025 FIN SHALL pulse done=1 for exactly one cycle, clear busy in the same cycle, and return to IDLE.
REQ-026 A start in the FIN cycle SHALL be ignored; start is accepted from the following cycle.
REQ-027 Throughput with ready held high SHALL be one digit per 2 cycles; the first digit is valid 1 cycle after the accepted start.
REQ-028 Fraction bits beyond the precision emitted SHALL be truncated, never rounded.
REQ-029 The digit counter SHALL be $clog2(N_FRAC+1) bits wide.
REQ-030 N_FRAC=0 SHALL emit only the integer digit (plus '.' when ASCII=1).

Reset
REQ-031 rst=1 SHALL force IDLE and clear valid, done, busy, err, digit, the digit counter and the captured registers on the next rising edge.
REQ-032 rst SHALL take priority over start and ready.
REQ-033 rst asserted mid-conversion SHALL abort it with no done pulse.

Verification
REQ-034 W=8, INT_BITS=4, N_FRAC=4, ASCII=0, ready=1, binary=8'h2B -> digits 2,6,8,7,5 on consecutive valid cycles spaced 2 apart; done once; err=0.
REQ-035 Same parameters with ASCII=1 and binary=8'h28 -> 8'h32, 8'h2E, 8'h35, 8'h30, 8'h30, 8'h30; then done.
REQ-036 binary=8'h2B with ready low for 5 cycles while digit 6 is valid -> digit stays 6 and valid stays 1 for all 5 cycles; the sequence then resumes unchanged.
REQ-037 binary=8'hA0 -> no valid, err=1, done pulses 2 cycles after start, busy falls with done.
REQ-038 A second start pulsed mid-conversion -> ignored, with output identical to REQ-034. Then rst after the 2nd digit -> all outputs 0 next cycle, no done; a fresh start afterwards converts correctly.
REQ-039 Default parameters, binary = 4'h2 followed by the 396-bit fraction of e -> first 20 digits are 2,7,1,8,2,8,1,8,2,8,4,5,9,0,4,5,2,3,5,3.

Source files
------------

// File: rtl/frac_to_dec_stream.sv
// Streams the decimal expansion of a fixed-point binary value, one digit per handshake:
// the integer digit first, then N_FRAC fraction digits produced by repeated multiply-by-ten.
module frac_to_dec_stream #(
    parameter int unsigned W        = 400,
    parameter int unsigned INT_BITS = 4,
    parameter int unsigned N_FRAC   = 100,
    parameter int unsigned ASCII    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] binary,
    input  logic         ready,
    output logic [7:0]   digit,
    output logic         valid,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned FW = W - INT_BITS;
    localparam int unsigned CW = (N_FRAC > 0) ? $clog2(N_FRAC + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((N_FRAC > 0) ? N_FRAC - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StInt,
        StDot,
        StMul,
        StFrac,
        StFin
    } state_t;

    state_t              state_q;
    logic [INT_BITS-1:0] int_q;
    logic [FW-1:0]       frac_q;
    logic [CW-1:0]       cnt_q;

    logic [FW+3:0]       frac_ext;
    logic [FW+3:0]       prod;
    logic [INT_BITS-1:0] in_int;

    function automatic logic gt9(input logic [INT_BITS-1:0] v);
        return 32'(v) > 32'd9;
    endfunction

    function automatic logic [7:0] enc(input logic [3:0] d);
        return (ASCII != 0) ? (8'h30 + {4'h0, d}) : {4'h0, d};
    endfunction

    // f*10 as a shift-add; the top nibble is the next decimal digit.
    always_comb begin
        frac_ext = {4'h0, frac_q};
        prod     = (frac_ext << 3) + (frac_ext << 1);
        in_int   = binary[W-1 -: INT_BITS];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            int_q   <= '0;
            frac_q  <= '0;
            cnt_q   <= '0;
            digit   <= 8'h00;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        int_q   <= in_int;
                        frac_q  <= binary[FW-1:0];
                        cnt_q   <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        // Integer digit is presented in the very next cycle.
                        valid   <= !gt9(in_int);
                        digit   <= gt9(in_int) ? 8'h00 : enc(4'(in_int));
                        state_q <= StInt;
                    end
                end
                StInt: begin
                    if (gt9(int_q)) begin
                        err     <= 1'b1;
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StFin;
                    end else if (ready) begin
                        if (ASCII != 0) begin
                            digit   <= 8'h2E;
                            state_q <= StDot;
                        end else if (N_FRAC == 0) begin
                            valid   <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            valid   <= 1'b0;
                            state_q <= StMul;
                        end
                    end
                end
                StDot: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (N_FRAC == 0) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            state_q <= StMul;
                        end
                    end
                end
                StMul: begin
                    digit   <= enc(prod[FW+3:FW]);
                    frac_q  <= prod[FW-1:0];
                    valid   <= 1'b1;
                    state_q <= StFrac;
                end
                StFrac: begin
                    if (ready) begin
                        valid <= 1'b0;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            state_q <= StMul;
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frac_to_dec_stream.sv
// Directed bench: three instances (small BCD, small ASCII, default width) driven by scenario tasks.
module tb_frac_to_dec_stream;

    logic clk = 1'b0;
    logic rst;
    logic ready;

    logic         start_a, start_b, start_c;
    logic [7:0]   bin_a, bin_b;
    logic [399:0] bin_c;

    logic [7:0] digit_a, digit_b, digit_c;
    logic valid_a, valid_b, valid_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    logic err_a, err_b, err_c;

    always #5 clk = ~clk;

    frac_to_dec_stream #(.W(8), .INT_BITS(4), .N_FRAC(4), .ASCII(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .binary(bin_a), .ready(ready),
        .digit(digit_a), .valid(valid_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    frac_to_dec_stream #(.W(8), .INT_BITS(4), .N_FRAC(4), .ASCII(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .binary(bin_b), .ready(ready),
        .digit(digit_b), .valid(valid_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    frac_to_dec_stream dut_c (
        .clk(clk), .rst(rst), .start(start_c), .binary(bin_c), .ready(ready),
        .digit(digit_c), .valid(valid_c), .busy(busy_c), .done(done_c), .err(err_c)
    );

    int n_pass = 0;
    int n_total = 0;

    int sel;
    logic [7:0] m_digit;
    logic m_valid, m_busy, m_done, m_err;

    always_comb begin
        m_digit = digit_a;
        m_valid = valid_a;
        m_busy  = busy_a;
        m_done  = done_a;
        m_err   = err_a;
        if (sel == 1) begin
            m_digit = digit_b; m_valid = valid_b; m_busy = busy_b; m_done = done_b; m_err = err_b;
        end else if (sel == 2) begin
            m_digit = digit_c; m_valid = valid_c; m_busy = busy_c; m_done = done_c; m_err = err_c;
        end
    end

    logic [7:0] got[$];
    int gt[$];
    int done_cnt;
    int done_t;
    logic err_at_done;
    logic busy_at_done;

    // Leaves the bench at the negedge one cycle after the accepted start (t = 1).
    task automatic pulse_start(input int s, input logic [399:0] b);
        sel = s;
        @(negedge clk);
        if (s == 0) begin start_a = 1'b1; bin_a = b[7:0]; end
        else if (s == 1) begin start_b = 1'b1; bin_b = b[7:0]; end
        else begin start_c = 1'b1; bin_c = b; end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    // Records handshaken digits with their cycle index until done or the budget runs out.
    task automatic collect(input int t_start, input int budget, input int poke1, input int poke2);
        got.delete();
        gt.delete();
        done_cnt = 0;
        done_t = 0;
        err_at_done = 1'b0;
        busy_at_done = 1'b1;
        for (int t = t_start; t < t_start + budget; t++) begin
            if (m_valid && ready) begin
                got.push_back(m_digit);
                gt.push_back(t);
            end
            if (m_done) begin
                done_cnt++;
                done_t = t;
                err_at_done = m_err;
                busy_at_done = m_busy;
            end
            if (sel == 0) begin
                start_a = (t == poke1) || (t == poke2);
                if (start_a) bin_a = 8'hFF;
            end
            if (m_done) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        n_total++; if (digit_a !== 8'h00) $display("FAIL reset_digit: got %0h want 0", digit_a); else n_pass++;
        n_total++; if (valid_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_a); else n_pass++;
        n_total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
        n_total++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else n_pass++;
        n_total++; if (err_a !== 1'b0) $display("FAIL reset_err: got %b want 0", err_a); else n_pass++;
    endtask

    task automatic check_2b_run(input string name);
        logic [7:0] exp [5];
        logic [7:0] g;
        int tt;
        exp = '{8'h02, 8'h06, 8'h08, 8'h07, 8'h05};
        n_total++;
        if (got.size() != 5) $display("FAIL %s_count: got %0d want 5", name, got.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            tt = (i < gt.size()) ? gt[i] : -1;
            n_total++;
            if (g !== exp[i] || tt != 1 + 2 * i)
                $display("FAIL %s_digit%0d: got %0h@%0d want %0h@%0d", name, i, g, tt, exp[i], 1 + 2 * i);
            else n_pass++;
        end
        n_total++;
        if (done_cnt != 1 || done_t != 10)
            $display("FAIL %s_done: got %0d pulses @%0d want 1 @10", name, done_cnt, done_t);
        else n_pass++;
        n_total++;
        if (err_at_done !== 1'b0 || busy_at_done !== 1'b0)
            $display("FAIL %s_flags: got err=%b busy=%b want err=0 busy=0", name, err_at_done, busy_at_done);
        else n_pass++;
    endtask

    task automatic test_basic();
        ready = 1'b1;
        pulse_start(0, 400'h2B);
        n_total++; if (busy_a !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy_a); else n_pass++;
        collect(1, 40, 0, 0);
        check_2b_run("basic");
    endtask

    task automatic test_ascii();
        logic [7:0] exp [6];
        int et [6];
        logic [7:0] g;
        int tt;
        exp = '{8'h32, 8'h2E, 8'h35, 8'h30, 8'h30, 8'h30};
        et = '{1, 2, 4, 6, 8, 10};
        ready = 1'b1;
        pulse_start(1, 400'h28);
        collect(1, 40, 0, 0);
        n_total++;
        if (got.size() != 6) $display("FAIL ascii_count: got %0d want 6", got.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            tt = (i < gt.size()) ? gt[i] : -1;
            n_total++;
            if (g !== exp[i] || tt != et[i])
                $display("FAIL ascii_digit%0d: got %0h@%0d want %0h@%0d", i, g, tt, exp[i], et[i]);
            else n_pass++;
        end
        n_total++;
        if (done_cnt != 1 || done_t != 11)
            $display("FAIL ascii_done: got %0d pulses @%0d want 1 @11", done_cnt, done_t);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [7:0] exp [4];
        logic [7:0] g;
        exp = '{8'h06, 8'h08, 8'h07, 8'h05};
        ready = 1'b1;
        pulse_start(0, 400'h2B);
        n_total++;
        if (valid_a !== 1'b1 || digit_a !== 8'h02)
            $display("FAIL stall_first: got v=%b d=%0h want v=1 d=2", valid_a, digit_a);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (valid_a !== 1'b1 || digit_a !== 8'h06)
            $display("FAIL stall_pre: got v=%b d=%0h want v=1 d=6", valid_a, digit_a);
        else n_pass++;
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_total++;
            if (valid_a !== 1'b1 || digit_a !== 8'h06)
                $display("FAIL stall_hold%0d: got v=%b d=%0h want v=1 d=6", k, valid_a, digit_a);
            else n_pass++;
        end
        ready = 1'b1;
        collect(8, 30, 0, 0);
        n_total++;
        if (got.size() != 4) $display("FAIL stall_count: got %0d want 4", got.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_total++;
            if (g !== exp[i]) $display("FAIL stall_resume%0d: got %0h want %0h", i, g, exp[i]);
            else n_pass++;
        end
        n_total++;
        if (done_cnt != 1) $display("FAIL stall_done: got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_err();
        ready = 1'b1;
        pulse_start(0, 400'hA0);
        n_total++;
        if (valid_a !== 1'b0 || busy_a !== 1'b1)
            $display("FAIL err_int: got v=%b busy=%b want v=0 busy=1", valid_a, busy_a);
        else n_pass++;
        collect(1, 20, 0, 0);
        n_total++;
        if (got.size() != 0) $display("FAIL err_nodigit: got %0d digits want 0", got.size()); else n_pass++;
        n_total++;
        if (done_cnt != 1 || done_t != 2)
            $display("FAIL err_done: got %0d pulses @%0d want 1 @2", done_cnt, done_t);
        else n_pass++;
        n_total++;
        if (err_at_done !== 1'b1 || busy_at_done !== 1'b0)
            $display("FAIL err_flags: got err=%b busy=%b want err=1 busy=0", err_at_done, busy_at_done);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (err_a !== 1'b1 || done_a !== 1'b0)
            $display("FAIL err_hold: got err=%b done=%b want err=1 done=0", err_a, done_a);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        ready = 1'b1;
        pulse_start(0, 400'h2B);
        n_total++; if (err_a !== 1'b0) $display("FAIL ign_errclr: got %b want 0", err_a); else n_pass++;
        // Starts land in a MUL cycle and in the FIN cycle.
        collect(1, 40, 4, 10);
        check_2b_run("ignore");
        @(negedge clk);
        start_a = 1'b0;
        n_total++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0)
            $display("FAIL ign_fin: got busy=%b v=%b want 0 0", busy_a, valid_a);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic seen;
        ready = 1'b1;
        pulse_start(0, 400'h2B);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({digit_a, valid_a, busy_a, done_a, err_a} !== 12'h000)
            $display("FAIL abort_zero: got d=%0h v=%b b=%b dn=%b e=%b want all 0",
                     digit_a, valid_a, busy_a, done_a, err_a);
        else n_pass++;
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL abort_nodone: got %b want 0", seen); else n_pass++;
        pulse_start(0, 400'h2B);
        collect(1, 40, 0, 0);
        check_2b_run("after_abort");
    endtask

    task automatic test_long();
        logic [395:0] e_frac;
        logic [7:0] exp [20];
        logic [7:0] g;
        // Fraction of e to 128 bits, ample for the 20 digits compared.
        e_frac = {128'hB7E151628AED2A6ABF7158809CF4F3C7, 268'h0};
        exp = '{8'd2, 8'd7, 8'd1, 8'd8, 8'd2, 8'd8, 8'd1, 8'd8, 8'd2, 8'd8,
                8'd4, 8'd5, 8'd9, 8'd0, 8'd4, 8'd5, 8'd2, 8'd3, 8'd5, 8'd3};
        ready = 1'b1;
        pulse_start(2, {4'h2, e_frac});
        collect(1, 400, 0, 0);
        n_total++;
        if (got.size() != 101) $display("FAIL e_count: got %0d want 101", got.size()); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_total++;
            if (g !== exp[i]) $display("FAIL e_digit%0d: got %0h want %0h", i, g, exp[i]);
            else n_pass++;
        end
        n_total++;
        if (done_cnt != 1 || done_t != 202)
            $display("FAIL e_done: got %0d pulses @%0d want 1 @202", done_cnt, done_t);
        else n_pass++;
    endtask

    initial begin
        sel = 0;
        rst = 1'b1;
        ready = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        bin_a = '0; bin_b = '0; bin_c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_ascii();
        test_stall();
        test_err();
        test_ignore_start();
        test_abort();
        test_long();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
